stopwatch: RTL and testbench

STOPWATCH -- requirements
Module: stopwatch

---
 rtl/stopwatch.sv | 243 ++++++++++++++++++++++++
 tb/tb_stopwatch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch.sv
// -----------------------------------------------------------------------------
// stopwatch -- m.ss.t stopwatch driving a 4-digit multiplexed 7-segment display
//
// Counts tenths of a second while running (start/stop level controls) and
// scans the four BCD digits onto a shared active-low segment bus.
//
// Parameters
//   TICK_NS      clock cycles per 0.1 s tick (>= 2)
//   REFRESH_BITS width of the free-running scan counter (>= 2); each digit is
//                lit for 2^(REFRESH_BITS-2) cycles
//
// Ports
//   clk_i    in   1  clock, all state on rising edge
//   rst_i    in   1  asynchronous active-low reset
//   start_i  in   1  run request (level)
//   stop_i   in   1  halt request (level, dominates start_i)
//   an_o     out  4  digit anodes, active-low, bit 0 = rightmost (tenths)
//   sseg_o   out  7  segment cathodes {g,f,e,d,c,b,a}, active-low
//   dp_o     out  1  decimal point cathode, active-low
//
// Build option
//   STOPWATCH_LZ_BLANK_EN  when defined, the minutes digit is blanked
//                          (segments and dp off) while minutes == 0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module stopwatch #(
  parameter int TICK_NS      = 10000000,
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       stop_i,
  output logic [3:0] an_o,
  output logic [6:0] sseg_o,
  output logic       dp_o
);

  localparam int TICK_W = $clog2(TICK_NS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_NS - 1);

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_e;

  run_state_e              state_r;
  run_state_e              state_next_s;
  logic                    running_s;

  logic [TICK_W-1:0]       tick_r;
  logic                    tick_wrap_s;

  logic [3:0]              tenths_r;
  logic [3:0]              secs_r;
  logic [3:0]              tens_r;
  logic [3:0]              mins_r;
  logic [3:0]              tenths_next_s;
  logic [3:0]              secs_next_s;
  logic [3:0]              tens_next_s;
  logic [3:0]              mins_next_s;

  logic [REFRESH_BITS-1:0] scan_r;
  logic [1:0]              sel_s;
  logic [3:0]              digit_s;
  logic                    blank_s;

  // BCD digit to active-low {g,f,e,d,c,b,a}; non-BCD codes show nothing
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Run/stop state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_STOPPED;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Run/stop next state: stop dominates start, otherwise hold
  always_comb begin
    state_next_s = state_r;
    if (stop_i) begin
      state_next_s = ST_STOPPED;
    end else if (start_i) begin
      state_next_s = ST_RUNNING;
    end else begin
      state_next_s = state_r;
    end
  end

  // Run/stop decoded output
  always_comb begin
    running_s = 1'b0;
    case (state_r)
      ST_RUNNING: running_s = 1'b1;
      ST_STOPPED: running_s = 1'b0;
      default:    running_s = 1'b0;
    endcase
  end

  assign tick_wrap_s = running_s && (tick_r == TICK_LAST);

  // Tenth-of-a-second prescaler; holds its partial count while stopped
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tick_r <= {TICK_W{1'b0}};
    end else if (tick_wrap_s) begin
      tick_r <= {TICK_W{1'b0}};
    end else if (running_s) begin
      tick_r <= tick_r + TICK_W'(1);
    end else begin
      tick_r <= tick_r;
    end
  end

  // Digit advance with the whole carry chain resolved in one edge;
  // 9.59.9 rolls over to 0.00.0
  always_comb begin
    tenths_next_s = tenths_r;
    secs_next_s   = secs_r;
    tens_next_s   = tens_r;
    mins_next_s   = mins_r;
    if (tick_wrap_s) begin
      if (tenths_r == 4'd9) begin
        tenths_next_s = 4'd0;
        if (secs_r == 4'd9) begin
          secs_next_s = 4'd0;
          if (tens_r == 4'd5) begin
            tens_next_s = 4'd0;
            if (mins_r == 4'd9) begin
              mins_next_s = 4'd0;
            end else begin
              mins_next_s = mins_r + 4'd1;
            end
          end else begin
            tens_next_s = tens_r + 4'd1;
          end
        end else begin
          secs_next_s = secs_r + 4'd1;
        end
      end else begin
        tenths_next_s = tenths_r + 4'd1;
      end
    end else begin
      tenths_next_s = tenths_r;
    end
  end

  // Digit registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tenths_r <= 4'd0;
      secs_r   <= 4'd0;
      tens_r   <= 4'd0;
      mins_r   <= 4'd0;
    end else begin
      tenths_r <= tenths_next_s;
      secs_r   <= secs_next_s;
      tens_r   <= tens_next_s;
      mins_r   <= mins_next_s;
    end
  end

  // Free-running display scan counter, independent of run state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scan_r <= {REFRESH_BITS{1'b0}};
    end else begin
      scan_r <= scan_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign sel_s = scan_r[REFRESH_BITS-1 -: 2];

`ifdef STOPWATCH_LZ_BLANK_EN
  assign blank_s = (sel_s == 2'd3) && (mins_r == 4'd0);
`else
  assign blank_s = 1'b0;
`endif

  // Display mux: anode select, digit value and decimal point (after s and m)
  always_comb begin
    an_o    = 4'b1111;
    digit_s = 4'd0;
    dp_o    = 1'b1;
    case (sel_s)
      2'd0: begin
        an_o    = 4'b1110;
        digit_s = tenths_r;
        dp_o    = 1'b1;
      end
      2'd1: begin
        an_o    = 4'b1101;
        digit_s = secs_r;
        dp_o    = 1'b0;
      end
      2'd2: begin
        an_o    = 4'b1011;
        digit_s = tens_r;
        dp_o    = 1'b1;
      end
      2'd3: begin
        an_o    = 4'b0111;
        digit_s = mins_r;
        dp_o    = blank_s;
      end
      default: begin
        an_o    = 4'b1111;
        digit_s = 4'd0;
        dp_o    = 1'b1;
      end
    endcase
  end

  // Segment decode of the selected digit, forced dark when blanked
  always_comb begin
    sseg_o = 7'b1111111;
    if (blank_s) begin
      sseg_o = 7'b1111111;
    end else begin
      sseg_o = seg_decode(digit_s);
    end
  end

endmodule

// File: tb/tb_stopwatch.sv
// -----------------------------------------------------------------------------
// tb_stopwatch -- scoreboard bench for stopwatch (TICK_NS=10, REFRESH_BITS=4)
//
// Stimulus pushes expected display slots {an, sseg, dp} into a queue. The
// monitor samples on the falling edge: an "immediate" entry must match the
// very next sample; any other entry is compared when the scan reaches its
// anode. Define STOPWATCH_LZ_BLANK_EN on both files to exercise blanking.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_stopwatch;

  logic       clk_i;
  logic       rst_i;
  logic       start_i;
  logic       stop_i;
  logic [3:0] an_o;
  logic [6:0] sseg_o;
  logic       dp_o;

  typedef struct packed {
    logic       imm;
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  mon_item;
  string cur_name = "none";
  int    checks_total  = 0;
  int    checks_passed = 0;

  stopwatch #(
    .TICK_NS      (10),
    .REFRESH_BITS (4)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .stop_i  (stop_i),
    .an_o    (an_o),
    .sseg_o  (sseg_o),
    .dp_o    (dp_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected slot for digit position sel (0 = tenths .. 3 = minutes)
  function automatic exp_t exp_for(input int sel, input int val, input logic imm);
    exp_t e;
    e.imm     = imm;
    e.an      = 4'b1111;
    e.an[sel] = 1'b0;
    e.sseg    = seg_of(val);
    e.dp      = (sel == 1 || sel == 3) ? 1'b0 : 1'b1;
`ifdef STOPWATCH_LZ_BLANK_EN
    if (sel == 3 && val == 0) begin
      e.sseg = 7'b1111111;
      e.dp   = 1'b1;
    end
`endif
    return e;
  endfunction

  // Monitor: pop and compare whenever the DUT presents the expected slot
  always @(negedge clk_i) begin
    if (sb_q.size() != 0) begin
      if (sb_q[0].imm || an_o == sb_q[0].an) begin
        mon_item = sb_q.pop_front();
        checks_total++;
        if (an_o === mon_item.an && sseg_o === mon_item.sseg && dp_o === mon_item.dp) begin
          checks_passed++;
        end else begin
          $display("FAIL %s: got an=%b sseg=%b dp=%b, expected an=%b sseg=%b dp=%b",
                   cur_name, an_o, sseg_o, dp_o, mon_item.an, mon_item.sseg, mon_item.dp);
        end
      end
    end
  end

  // Wait for the monitor to consume everything, bounded
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks_total++;
      $display("FAIL %s: timeout, %0d expected slots never shown, required 0", cur_name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_frame(input string name, input int m, input int s10, input int s1, input int t);
    cur_name = name;
    sb_q.push_back(exp_for(0, t,   1'b0));
    sb_q.push_back(exp_for(1, s1,  1'b0));
    sb_q.push_back(exp_for(2, s10, 1'b0));
    sb_q.push_back(exp_for(3, m,   1'b0));
    drain();
  endtask

  task automatic go();
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Exactly n counting edges, the last one sampling stop_i
  task automatic run_then_stop(input int n);
    repeat (n - 1) @(posedge clk_i);
    #1;
    stop_i = 1'b1;
    @(posedge clk_i);
    #1;
    stop_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i   = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i   = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    // Scan order right after release: 4 cycles per digit, all zeros
    cur_name = "scan_seq";
    for (int k = 0; k < 16; k++) begin
      sb_q.push_back(exp_for(k / 4, 0, 1'b1));
    end
    rst_i = 1'b1;
    drain();

    repeat (50) @(posedge clk_i);
    check_frame("idle_hold", 0, 0, 0, 0);

    go();
    run_then_stop(100);
    check_frame("run100", 0, 0, 1, 0);

    do_reset();
    check_frame("after_reset", 0, 0, 0, 0);
    go();
    run_then_stop(37);
    check_frame("partial37", 0, 0, 0, 3);
    repeat (200) @(posedge clk_i);
    check_frame("stopped_hold", 0, 0, 0, 3);
    go();
    run_then_stop(63);
    check_frame("resume63", 0, 0, 1, 0);

    do_reset();
    start_i = 1'b1;
    stop_i  = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    repeat (20) @(posedge clk_i);
    check_frame("both_high", 0, 0, 0, 0);

    go();
    run_then_stop(6000);
    check_frame("one_min", 1, 0, 0, 0);
    go();
    run_then_stop(53990);
    check_frame("max_9599", 9, 5, 9, 9);
    go();
    run_then_stop(10);
    check_frame("wrap", 0, 0, 0, 0);
    go();
    run_then_stop(12);
    check_frame("after_wrap", 0, 0, 0, 1);

    // Asynchronous reset between edges while running
    go();
    repeat (25) @(posedge clk_i);
    #2;
    rst_i    = 1'b0;
    cur_name = "async_reset";
    sb_q.push_back(exp_for(0, 0, 1'b1));
    drain();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    check_frame("post_reset", 0, 0, 0, 0);
    repeat (50) @(posedge clk_i);
    check_frame("post_reset_hold", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
